// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: byte-stream and pulse bundle between the UART
// receiver/transmitter side (master) and the command decoder (slave).
interface uart_cmd_decoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_busy;
   logic       mode_toggle_uart;
   logic       time_toggle_uart;
   logic       run_toggle_uart;
   logic       clear_uart;
   logic       cmd_err;
   logic [7:0] tx_data;
   logic       tx_start;

   modport master (
      output rx_data, rx_valid, tx_busy,
      input  mode_toggle_uart, time_toggle_uart, run_toggle_uart,
             clear_uart, cmd_err, tx_data, tx_start
   );

   modport slave (
      input  rx_data, rx_valid, tx_busy,
      output mode_toggle_uart, time_toggle_uart, run_toggle_uart,
             clear_uart, cmd_err, tx_data, tx_start
   );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: parses single-letter, CR/LF-terminated ASCII commands
// (M/T/R/C, case-insensitive) into one-cycle control pulses.
// Optional feature macro: UART_CMD_ECHO_EN -- returns 'K' after an executed
// command and '?' after a rejected/timed-out one via tx_start/tx_data.
module uart_cmd_decoder #(
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input logic                clk,
   input logic                rst,
   uart_cmd_decoder_if.slave  bus
);
   localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_FLUSH} state_t;
   typedef enum logic [1:0] {OP_MODE, OP_TIME, OP_RUN, OP_CLEAR} op_t;

   state_t        state_q, state_d;
   op_t           op_q, op_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    pulse_q, pulse_d;   // {clear, run, time, mode}
   logic          err_q, err_d;

   logic          is_term;
   logic          is_letter;
   op_t           letter_op;

   // Classify the incoming byte: terminator, command letter, or other.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      is_term   = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);
      is_letter = 1'b1;
      letter_op = OP_MODE;
      case (bus.rx_data)
         8'h4D, 8'h6D: letter_op = OP_MODE;
         8'h54, 8'h74: letter_op = OP_TIME;
         8'h52, 8'h72: letter_op = OP_RUN;
         8'h43, 8'h63: letter_op = OP_CLEAR;
         default:      is_letter = 1'b0;
      endcase
   end

   // Next-state, timeout counter and pulse decisions; a byte always beats a timeout.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      pulse_d = '0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (bus.rx_valid) begin
               if (is_letter) begin
                  op_d    = letter_op;
                  state_d = ST_CMD;
               end else if (!is_term) begin
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_CMD: begin
            if (bus.rx_valid) begin
               cnt_d = '0;
               if (is_term) begin
                  pulse_d = 4'b0001 << op_q;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FLUSH;
               end
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_FLUSH: begin
            if (bus.rx_valid) begin
               cnt_d = '0;
               if (is_term) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register and registered output pulses (1-cycle latency from the sampled byte).
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MODE;
         cnt_q   <= '0;
         pulse_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
         err_q   <= err_d;
      end
   end

   assign bus.mode_toggle_uart = pulse_q[0];
   assign bus.time_toggle_uart = pulse_q[1];
   assign bus.run_toggle_uart  = pulse_q[2];
   assign bus.clear_uart       = pulse_q[3];
   assign bus.cmd_err          = err_q;

`ifdef UART_CMD_ECHO_EN
   logic       pend_valid;
   logic [7:0] pend_data;
   logic [7:0] last_data;
   logic       send;

   // tx_start is gated directly by tx_busy so it can never assert while busy.
   assign send         = pend_valid && !bus.tx_busy;
   assign bus.tx_start = send;
   assign bus.tx_data  = send ? pend_data : last_data;

   // Single pending ack slot; a newer ack overwrites an unsent one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_valid <= 1'b0;
         pend_data  <= 8'h00;
         last_data  <= 8'h00;
      end else begin
         if (send) begin
            last_data  <= pend_data;
            pend_valid <= 1'b0;
         end
         if (err_d) begin
            pend_valid <= 1'b1;
            pend_data  <= 8'h3F;
         end else if (|pulse_d) begin
            pend_valid <= 1'b1;
            pend_data  <= 8'h4B;
         end
      end
   end
`else
   logic unused_tx_busy;
   assign unused_tx_busy = bus.tx_busy;
   assign bus.tx_start   = 1'b0;
   assign bus.tx_data    = 8'h00;
`endif
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: line-oriented reference model plus directed checks
// for uart_cmd_decoder with TIMEOUT_CYCLES=16.
module tb_uart_cmd_decoder;
   localparam int T = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_cmd_decoder_if bus();

   uart_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model: whole-line view of the byte stream
   int         line_len = 0;      // bytes received since the last line end
   logic [7:0] line_first = 8'h00;
   int         idle_cnt = 0;      // edges without a byte since the last byte
   logic       e_mode = 0, e_time = 0, e_run = 0, e_clear = 0, e_err = 0;
   logic       m_pend = 0;
   logic [7:0] m_pend_data = 8'h00, m_last = 8'h00;

   function automatic logic [7:0] upper(input logic [7:0] b);
      return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
   endfunction

   function automatic bit is_cmd_letter(input logic [7:0] b);
      logic [7:0] u;
      u = upper(b);
      return (u == "M") || (u == "T") || (u == "R") || (u == "C");
   endfunction

   task automatic model_reset();
      line_len = 0; idle_cnt = 0;
      e_mode = 0; e_time = 0; e_run = 0; e_clear = 0; e_err = 0;
      m_pend = 0; m_pend_data = 8'h00; m_last = 8'h00;
   endtask

   task automatic model_edge(input logic v, input logic [7:0] d);
      bit ok, bad;
      logic [7:0] u;
      if (rst) begin
         model_reset();
         return;
      end
      ok = 0; bad = 0;
      e_mode = 0; e_time = 0; e_run = 0; e_clear = 0; e_err = 0;
      if (m_pend && !bus.tx_busy) begin
         m_last = m_pend_data;
         m_pend = 0;
      end
      if (v) begin
         idle_cnt = 0;
         if (d == 8'h0D || d == 8'h0A) begin
            if (line_len == 1 && is_cmd_letter(line_first)) ok = 1;
            else if (line_len != 0) bad = 1;
            line_len = 0;
         end else begin
            if (line_len == 0) line_first = d;
            line_len++;
         end
      end else if (line_len != 0) begin
         idle_cnt++;
         if (idle_cnt == T) begin
            if (line_len == 1 && is_cmd_letter(line_first)) bad = 1;
            line_len = 0;
            idle_cnt = 0;
         end
      end
      if (ok) begin
         u = upper(line_first);
         e_mode  = (u == "M");
         e_time  = (u == "T");
         e_run   = (u == "R");
         e_clear = (u == "C");
      end
      e_err = bad;
`ifdef UART_CMD_ECHO_EN
      if (ok)  begin m_pend = 1; m_pend_data = 8'h4B; end
      if (bad) begin m_pend = 1; m_pend_data = 8'h3F; end
`endif
   endtask

   // ---------------- compare process, plus DUT-observed event counters
   int   n_mode = 0, n_time = 0, n_run = 0, n_clear = 0, n_err = 0, n_tx = 0;
   int   err_cyc = -1;
   logic [7:0] tx_seen = 8'h00;

   always @(negedge clk) begin
      logic       x_start;
      logic [7:0] x_data;
`ifdef UART_CMD_ECHO_EN
      x_start = m_pend && !bus.tx_busy && !rst;
      x_data  = x_start ? m_pend_data : m_last;
`else
      x_start = 1'b0;
      x_data  = 8'h00;
`endif
      check("mode_toggle_uart", bus.mode_toggle_uart, e_mode);
      check("time_toggle_uart", bus.time_toggle_uart, e_time);
      check("run_toggle_uart",  bus.run_toggle_uart,  e_run);
      check("clear_uart",       bus.clear_uart,       e_clear);
      check("cmd_err",          bus.cmd_err,          e_err);
      check("tx_start",         bus.tx_start,         x_start);
      check("tx_data",          bus.tx_data,          x_data);
      if (bus.mode_toggle_uart) n_mode++;
      if (bus.time_toggle_uart) n_time++;
      if (bus.run_toggle_uart)  n_run++;
      if (bus.clear_uart)       n_clear++;
      if (bus.cmd_err) begin n_err++; err_cyc = cyc; end
      if (bus.tx_start) begin n_tx++; tx_seen = bus.tx_data; end
   end

   // ---------------- stimulus helpers
   task automatic step(input logic v, input logic [7:0] d);
      bus.rx_valid = v;
      bus.rx_data  = d;
      @(posedge clk);
      model_edge(v, d);
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 8'h00);
   endtask

   int b_mode, b_time, b_run, b_clear, b_err, b_tx;
   task automatic mark();
      b_mode = n_mode; b_time = n_time; b_run = n_run;
      b_clear = n_clear; b_err = n_err; b_tx = n_tx;
   endtask

   task automatic expect_counts(input string tag, input int m, input int t,
                                input int r, input int c, input int e);
      check({tag, " mode pulses"},  n_mode  - b_mode,  m);
      check({tag, " time pulses"},  n_time  - b_time,  t);
      check({tag, " run pulses"},   n_run   - b_run,   r);
      check({tag, " clear pulses"}, n_clear - b_clear, c);
      check({tag, " cmd_err"},      n_err   - b_err,   e);
   endtask

   initial begin
      int c_cyc;
      int r;
      logic [7:0] b;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_busy  = 1'b0;
      model_reset();
      idle(3);
      check("reset tx_data", bus.tx_data, 8'h00);
      rst = 1'b0;
      idle(2);

      // 'M' CR then 't' LF: one mode pulse one cycle after CR, then one time pulse
      mark();
      step(1'b1, "M"); step(1'b1, 8'h0D);
      check("mode pulse 1 cycle after CR", bus.mode_toggle_uart, 1'b1);
      step(1'b1, "t"); step(1'b1, 8'h0A);
      check("time pulse 1 cycle after LF", bus.time_toggle_uart, 1'b1);
      idle(3);
      expect_counts("M/t", 1, 1, 0, 0, 0);

      // 'R' CR LF back-to-back: single run pulse
      mark();
      step(1'b1, "R"); step(1'b1, 8'h0D); step(1'b1, 8'h0A);
      idle(3);
      expect_counts("R CRLF", 0, 0, 1, 0, 0);

      // unknown letter, then two letters: errors only
      mark();
      step(1'b1, "X"); step(1'b1, 8'h0D);
      check("err 1 cycle after CR", bus.cmd_err, 1'b1);
      step(1'b1, "M"); step(1'b1, "T"); step(1'b1, 8'h0D);
      idle(3);
      expect_counts("X / MT", 0, 0, 0, 0, 2);

      // CMD timeout: cmd_err exactly T cycles after the letter edge; late CR ignored
      mark();
      step(1'b1, "C");
      c_cyc = cyc;
      idle(T + 4);
      check("timeout latency", err_cyc - c_cyc, T);
      step(1'b1, 8'h0D);
      idle(3);
      expect_counts("timeout", 0, 0, 0, 0, 1);

      // Reset mid-command drops it; following CR in IDLE ignored
      mark();
      step(1'b1, "M");
      rst = 1'b1;
      model_reset();
      idle(3);
      rst = 1'b0;
      step(1'b1, 8'h0D);
      idle(3);
      expect_counts("reset mid-cmd", 0, 0, 0, 0, 0);

`ifdef UART_CMD_ECHO_EN
      // Pending ack overwritten while busy: only '?' goes out
      mark();
      bus.tx_busy = 1'b1;
      step(1'b1, "M"); step(1'b1, 8'h0D);
      step(1'b1, "Q"); step(1'b1, 8'h0D);
      idle(3);
      check("no tx_start while busy", n_tx - b_tx, 0);
      bus.tx_busy = 1'b0;
      idle(4);
      check("single tx_start", n_tx - b_tx, 1);
      check("ack byte", tx_seen, 8'h3F);
`endif

      // Randomized traffic checked cycle-by-cycle against the model
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 199);
         if ($urandom_range(0, 9) == 0) bus.tx_busy = ~bus.tx_busy;
         if (r < 85) begin
            step(1'b0, 8'h00);
         end else if (r < 140) begin
            case ($urandom_range(0, 3))
               0: b = "M";
               1: b = "T";
               2: b = "R";
               default: b = "C";
            endcase
            if ($urandom_range(0, 1) == 1) b = b + 8'h20;
            step(1'b1, b);
         end else if (r < 180) begin
            step(1'b1, ($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
         end else if (r < 193) begin
            b = 8'($urandom_range(0, 255));
            step(1'b1, b);
         end else if (r < 198) begin
            idle(T + $urandom_range(0, 3) - 2);
         end else begin
            rst = 1'b1;
            model_reset();
            idle(2);
            rst = 1'b0;
         end
      end
      bus.tx_busy = 1'b0;
      idle(T + 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
